// File: rtl/video_raster_ctrl.sv
// Raster timing generator with a centred, integer-scaled source window.
// Scale changes arrive via valid/ready and take effect only at the frame wrap.
module video_raster_ctrl #(
  parameter int unsigned H_TOTAL       = 1040,
  parameter int unsigned V_TOTAL       = 748,
  parameter int unsigned H_FP          = 40,
  parameter int unsigned H_BLANK       = 240,
  parameter int unsigned V_FP          = 3,
  parameter int unsigned V_BLANK       = 28,
  parameter int unsigned H_ACTIVE      = 800,
  parameter int unsigned V_ACTIVE      = 720,
  parameter int unsigned SRC_W         = 128,
  parameter int unsigned SRC_H         = 64,
  parameter int unsigned DEFAULT_SCALE = 6
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [2:0] cfg_scale,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       cfg_err,
  output logic       vs,
  output logic       hs,
  output logic       de,
  output logic       in_window,
  output logic [6:0] raster_x,
  output logic [5:0] raster_y,
  output logic       frame_start,
  output logic [2:0] active_scale
);

  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_FP_C   = HW'(H_FP);
  localparam logic [HW-1:0] H_BLK_C  = HW'(H_BLANK);
  localparam logic [VW-1:0] V_FP_C   = VW'(V_FP);
  localparam logic [VW-1:0] V_BLK_C  = VW'(V_BLANK);
  localparam logic [2:0]    RST_SCL  = 3'(DEFAULT_SCALE);
  localparam int unsigned   RST_W    = SRC_W * DEFAULT_SCALE;
  localparam int unsigned   RST_H    = SRC_H * DEFAULT_SCALE;
  localparam logic [HW-1:0] RST_X_LO = HW'(H_BLANK + (H_ACTIVE - RST_W) / 2);
  localparam logic [HW-1:0] RST_X_HI = HW'(H_BLANK + (H_ACTIVE - RST_W) / 2 + RST_W);
  localparam logic [VW-1:0] RST_Y_LO = VW'(V_BLANK + (V_ACTIVE - RST_H) / 2);
  localparam logic [VW-1:0] RST_Y_HI = VW'(V_BLANK + (V_ACTIVE - RST_H) / 2 + RST_H);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [HW-1:0] r_x_lo, r_x_hi;
  logic [VW-1:0] r_y_lo, r_y_hi;
  logic [2:0]    r_scale;
  logic [2:0]    r_pend_scale;
  logic [2:0]    r_sub_x;
  logic [2:0]    r_sub_y;
  logic [5:0]    r_row;

  logic [HW-1:0] w_win_w, w_x_lo, w_x_hi;
  logic [VW-1:0] w_win_h, w_y_lo, w_y_hi;
  logic          w_h_last, w_frame_wrap;
  logic          w_de, w_in, w_left, w_vs_hit;
  logic [2:0]    w_scale_m1;
  logic [2:0]    w_suby_n;
  logic [5:0]    w_row_n;
  logic          w_cfg_acc, w_cfg_bad;

  // Window size for the pending scale built as a sum of shifted source dims.
  always_comb begin
    w_win_w = '0;
    w_win_h = '0;
    if (r_pend_scale[0]) begin
      w_win_w = w_win_w + HW'(SRC_W);
      w_win_h = w_win_h + VW'(SRC_H);
    end
    if (r_pend_scale[1]) begin
      w_win_w = w_win_w + HW'(SRC_W << 1);
      w_win_h = w_win_h + VW'(SRC_H << 1);
    end
    if (r_pend_scale[2]) begin
      w_win_w = w_win_w + HW'(SRC_W << 2);
      w_win_h = w_win_h + VW'(SRC_H << 2);
    end
    w_x_lo = H_BLK_C + ((HW'(H_ACTIVE) - w_win_w) >> 1);
    w_x_hi = w_x_lo + w_win_w;
    w_y_lo = V_BLK_C + ((VW'(V_ACTIVE) - w_win_h) >> 1);
    w_y_hi = w_y_lo + w_win_h;
  end

  always_comb begin
    w_h_last     = (r_h == H_LAST);
    w_frame_wrap = w_h_last && (r_v == V_LAST);
    w_de         = (r_h >= H_BLK_C) && (r_v >= V_BLK_C);
    w_in         = w_de && (r_h >= r_x_lo) && (r_h < r_x_hi)
                        && (r_v >= r_y_lo) && (r_v < r_y_hi);
    w_left       = w_in && (r_h == r_x_lo);
    w_vs_hit     = (r_h == '0) && (r_v == V_FP_C);
    w_scale_m1   = r_scale - 3'd1;
    w_cfg_acc    = cfg_valid && cfg_ready;
    w_cfg_bad    = (cfg_scale == 3'd0) || (cfg_scale == 3'd7);
  end

  // Line sub-counter advances once per window line, on its left-edge pixel.
  always_comb begin
    w_row_n  = r_row;
    w_suby_n = r_sub_y;
    if (r_v == r_y_lo) begin
      w_row_n  = '0;
      w_suby_n = '0;
    end else if (r_sub_y == w_scale_m1) begin
      w_row_n  = r_row + 6'd1;
      w_suby_n = '0;
    end else begin
      w_suby_n = r_sub_y + 3'd1;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_h          <= '0;
      r_v          <= '0;
      r_x_lo       <= RST_X_LO;
      r_x_hi       <= RST_X_HI;
      r_y_lo       <= RST_Y_LO;
      r_y_hi       <= RST_Y_HI;
      r_scale      <= RST_SCL;
      r_pend_scale <= RST_SCL;
      r_sub_x      <= '0;
      r_sub_y      <= '0;
      r_row        <= '0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      vs           <= 1'b0;
      hs           <= 1'b0;
      de           <= 1'b0;
      in_window    <= 1'b0;
      frame_start  <= 1'b0;
      raster_x     <= '0;
      raster_y     <= '0;
      active_scale <= RST_SCL;
    end else begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end

      vs           <= w_vs_hit;
      hs           <= (r_h == H_FP_C) && !w_vs_hit;
      de           <= w_de;
      in_window    <= w_in;
      frame_start  <= (r_h == '0) && (r_v == '0);
      active_scale <= r_scale;

      if (!w_in || w_left) begin
        r_sub_x  <= '0;
        raster_x <= '0;
      end else if (r_sub_x == w_scale_m1) begin
        r_sub_x  <= '0;
        raster_x <= raster_x + 7'd1;
      end else begin
        r_sub_x  <= r_sub_x + 3'd1;
      end

      if (w_left) begin
        r_row   <= w_row_n;
        r_sub_y <= w_suby_n;
      end
      raster_y <= !w_in ? '0 : (w_left ? w_row_n : r_row);

      // Accept needs cfg_ready=1 and apply needs cfg_ready=0, so an accept on
      // the wrap cycle naturally waits for the following wrap.
      cfg_err <= 1'b0;
      if (w_cfg_acc) begin
        if (w_cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          r_pend_scale <= cfg_scale;
          cfg_ready    <= 1'b0;
        end
      end
      if (w_frame_wrap && !cfg_ready) begin
        r_scale   <= r_pend_scale;
        r_x_lo    <= w_x_lo;
        r_x_hi    <= w_x_hi;
        r_y_lo    <= w_y_lo;
        r_y_hi    <= w_y_hi;
        cfg_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_raster_ctrl.sv
// Bench for video_raster_ctrl on a reduced raster (64x33, 8x4 source) so
// several whole frames fit in a short run; pixel outputs follow an arithmetic model.
module tb_video_raster_ctrl;

  localparam int HT  = 64;
  localparam int VT  = 33;
  localparam int HFP = 4;
  localparam int HB  = 12;
  localparam int VFP = 1;
  localparam int VB  = 3;
  localparam int HA  = 52;
  localparam int VA  = 30;
  localparam int SW  = 8;
  localparam int SH  = 4;
  localparam int FR  = HT * VT;

  logic       clk_pixel;
  logic       reset_n;
  logic [2:0] cfg_scale;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_err;
  logic       vs, hs, de, in_window, frame_start;
  logic [6:0] raster_x;
  logic [5:0] raster_y;
  logic [2:0] active_scale;

  int n_tot = 0;
  int n_bad = 0;
  int cyc;
  int sch [0:7];

  video_raster_ctrl #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_FP(HFP), .H_BLANK(HB), .V_FP(VFP),
    .V_BLANK(VB), .H_ACTIVE(HA), .V_ACTIVE(VA), .SRC_W(SW), .SRC_H(SH),
    .DEFAULT_SCALE(6)
  ) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .cfg_scale(cfg_scale),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .vs(vs), .hs(hs), .de(de), .in_window(in_window), .raster_x(raster_x),
    .raster_y(raster_y), .frame_start(frame_start), .active_scale(active_scale)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Number of DUT clock edges since reset release; outputs show state cyc-1.
  always @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  int m_scale;
  int a_vs, a_hs, a_de, a_win, a_rx, a_ry;

  always @(negedge clk_pixel) begin
    int idx, h, v, fr, s, w, hh, xo, yo, rx, ry;
    logic vs_e, hs_e, de_e, win_e, fs_e;
    logic [20:0] got, exp;
    got = {vs, hs, de, in_window, frame_start, raster_x, raster_y, active_scale};
    if (!reset_n || cyc == 0) begin
      m_scale = 6;
      a_vs = 0; a_hs = 0; a_de = 0; a_win = 0; a_rx = 0; a_ry = 0;
      chk("reset_outputs", 32'(got), 32'({18'd0, 3'd6}));
    end else begin
      idx = cyc - 1;
      h   = idx % HT;
      v   = (idx / HT) % VT;
      fr  = idx / FR;
      if (h == 0 && v == 0 && fr < 8 && sch[fr] != 0) m_scale = sch[fr];
      s     = m_scale;
      w     = SW * s;
      hh    = SH * s;
      xo    = (HA - w) / 2;
      yo    = (VA - hh) / 2;
      de_e  = (h >= HB) && (v >= VB);
      win_e = de_e && (h - HB >= xo) && (h - HB < xo + w)
                   && (v - VB >= yo) && (v - VB < yo + hh);
      rx    = win_e ? (h - HB - xo) / s : 0;
      ry    = win_e ? (v - VB - yo) / s : 0;
      vs_e  = (h == 0) && (v == VFP);
      hs_e  = (h == HFP) && !vs_e;
      fs_e  = (h == 0) && (v == 0);
      exp   = {vs_e, hs_e, de_e, win_e, fs_e, 7'(rx), 6'(ry), 3'(s)};
      chk($sformatf("pix_f%0d_h%0d_v%0d", fr, h, v), 32'(got), 32'(exp));
      a_vs  += int'(vs);
      a_hs  += int'(hs);
      a_de  += int'(de);
      a_win += int'(in_window);
      if (in_window && int'(raster_x) > a_rx) a_rx = int'(raster_x);
      if (in_window && int'(raster_y) > a_ry) a_ry = int'(raster_y);
      if (h == HT - 1 && v == VT - 1) begin
        chk($sformatf("f%0d_vs_count", fr), a_vs, 1);
        chk($sformatf("f%0d_hs_count", fr), a_hs, VT);
        chk($sformatf("f%0d_de_count", fr), a_de, HA * VA);
        chk($sformatf("f%0d_win_count", fr), a_win, w * hh);
        chk($sformatf("f%0d_rx_max", fr), a_rx, SW - 1);
        chk($sformatf("f%0d_ry_max", fr), a_ry, SH - 1);
        a_vs = 0; a_hs = 0; a_de = 0; a_win = 0; a_rx = 0; a_ry = 0;
      end
    end
  end

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 4 * FR) begin
      @(negedge clk_pixel);
      guard++;
    end
    if (cyc < target) chk("wait_timeout", cyc, target);
  endtask

  // Frame in which a request accepted on the edge leaving state a takes effect.
  function automatic int apply_frame(input int a);
    return (a + 1) / FR + 1;
  endfunction

  initial begin
    int t;
    for (int i = 0; i < 8; i++) sch[i] = 0;
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_scale = 3'd0;
    repeat (3) @(negedge clk_pixel);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_err", cfg_err, 0);
    reset_n = 1'b1;

    // Scale 5 mid frame 0, then scale 3 held while 5 is pending.
    wait_cyc(1000);
    cfg_scale = 3'd5;
    cfg_valid = 1'b1;
    sch[apply_frame(cyc)] = 5;
    @(negedge clk_pixel);
    cfg_scale = 3'd3;
    chk("pend_ready_low", cfg_ready, 0);
    @(negedge clk_pixel);
    chk("held_not_accepted", cfg_ready, 0);
    t = 0;
    while (!cfg_ready && t < 2 * FR) begin
      @(negedge clk_pixel);
      t++;
    end
    chk("ready_back_cycle", cyc, FR);
    sch[apply_frame(cyc)] = 3;
    @(negedge clk_pixel);
    cfg_valid = 1'b0;
    chk("held_accepted", cfg_ready, 0);

    // Out-of-range scales are consumed with an error pulse.
    wait_cyc(2 * FR + 100);
    chk("ready_frame2", cfg_ready, 1);
    for (int i = 0; i < 2; i++) begin
      cfg_scale = (i == 0) ? 3'd7 : 3'd0;
      cfg_valid = 1'b1;
      @(negedge clk_pixel);
      cfg_valid = 1'b0;
      chk($sformatf("err_pulse_%0d", i), cfg_err, 1);
      chk($sformatf("err_ready_%0d", i), cfg_ready, 1);
      @(negedge clk_pixel);
      chk($sformatf("err_clear_%0d", i), cfg_err, 0);
      chk($sformatf("err_ready2_%0d", i), cfg_ready, 1);
    end

    // Accept on the frame-wrap cycle waits for the following wrap.
    wait_cyc(3 * FR - 1);
    cfg_scale = 3'd1;
    cfg_valid = 1'b1;
    sch[apply_frame(cyc)] = 1;
    @(negedge clk_pixel);
    cfg_valid = 1'b0;
    chk("wrap_acc_ready", cfg_ready, 0);
    wait_cyc(3 * FR + 50);
    chk("wrap_acc_still_pend", cfg_ready, 0);
    wait_cyc(4 * FR);
    chk("wrap_acc_applied", cfg_ready, 1);

    // Reset inside the window with scale 5 pending.
    wait_cyc(4 * FR + 500);
    cfg_scale = 3'd5;
    cfg_valid = 1'b1;
    @(negedge clk_pixel);
    cfg_valid = 1'b0;
    chk("pre_rst_pending", cfg_ready, 0);
    wait_cyc(4 * FR + 17 * HT + 37);
    chk("pre_rst_in_window", in_window, 1);
    #3;
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) sch[i] = 0;
    #1;
    chk("rst_async_window", in_window, 0);
    chk("rst_async_de", de, 0);
    chk("rst_async_ready", cfg_ready, 1);
    chk("rst_async_scale", active_scale, 6);
    repeat (2) @(negedge clk_pixel);
    reset_n = 1'b1;
    wait_cyc(FR / 2);
    chk("post_rst_ready", cfg_ready, 1);
    wait_cyc(FR + 20);
    chk("post_rst_scale", active_scale, 6);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/video_raster_ctrl.md
Name: video_raster_ctrl

Overview:
- Programmable raster controller for the Pocket video output path. Generates the 1040x748 display timing and the single-cycle sync strobes.
- Places the 128x64 OLED image in a centred window at a runtime-selectable integer scale.
- Drives source pixel coordinates (raster_x/raster_y) to the SSD1306 VRAM read port.
- Takes scale changes through a valid/ready config handshake and applies them only at frame boundaries, so a frame never tears.

Parameters:
H_TOTAL, 1040, pixel clocks per line
V_TOTAL, 748, lines per frame
H_FP, 40, h_count at which hs pulses
H_BLANK, 240, first active h_count (front porch + sync + back porch)
V_FP, 3, v_count at which vs pulses
V_BLANK, 28, first active v_count
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 720, active lines
SRC_W, 128, source image width
SRC_H, 64, source image height
DEFAULT_SCALE, 6, scale loaded at reset

Ports:
clk_pixel  in  1  pixel clock; all logic in this domain
reset_n  in  1  asynchronous, active-low reset
cfg_scale  in  3  requested integer scale
cfg_valid  in  1  config request
cfg_ready  out  1  high when no request is pending
cfg_err  out  1  one-cycle pulse: request rejected
vs  out  1  one-cycle vertical sync strobe
hs  out  1  one-cycle horizontal sync strobe
de  out  1  active-area enable
in_window  out  1  current pixel is inside the scaled image window
raster_x  out  7  source column (0..SRC_W-1)
raster_y  out  6  source row (0..SRC_H-1)
frame_start  out  1  one-cycle pulse at h_count=0, v_count=0
active_scale  out  3  scale in effect for the current frame

Behaviour:
- Reset (asynchronous, reset_n low): h_count=0, v_count=0, no request pending, active_scale=DEFAULT_SCALE, offsets recomputed for that scale. Outputs: cfg_ready=1; vs, hs, de, in_window, frame_start, cfg_err = 0; raster_x=0, raster_y=0.
- Counters: h_count runs 0..H_TOTAL-1 and wraps to 0. v_count increments on each h wrap and runs 0..V_TOTAL-1, then wraps to 0.
- Output latency: every output is registered, one cycle after the counter state it decodes. All outputs share this latency, so they stay mutually aligned.
- Strobes:
  - vs=1 only for h_count=0 and v_count=V_FP.
  - hs=1 only for h_count=H_FP. vs has priority; on the vs cycle hs=0.
  - de=1 when h_count>=H_BLANK and v_count>=V_BLANK.
- Active coordinates: ax = h_count-H_BLANK, ay = v_count-V_BLANK.
- Window geometry: width = SRC_W*scale, height = SRC_H*scale, x_off = (H_ACTIVE-width)>>1, y_off = (V_ACTIVE-height)>>1. All are registered at apply time. The datapath has no dividers and no multipliers (shift-add only).
- in_window = de, with ax in [x_off, x_off+width) and ay in [y_off, y_off+height).
- Source coordinates:
  - A sub-pixel counter counts 0..scale-1 across in_window pixels. raster_x increments when it wraps and resets to 0 at window left edge.
  - A line sub-counter counts 0..scale-1 once per line inside the window. raster_y increments when it wraps and resets at window top.
  - Outside the window, raster_x=0 and raster_y=0.
  - A scale-6 line therefore reads each column exactly 6 times; the last in_window pixel has raster_x=127.
- Config handshake:
  - A request is accepted when cfg_valid && cfg_ready.
  - Valid scale range is 1..6. A scale of 0 or 7 is consumed but discarded: cfg_err pulses 1 cycle, cfg_ready stays 1, nothing becomes pending.
  - A valid scale becomes pending and cfg_ready drops on the next cycle.
  - The pending scale applies on the cycle h_count wraps to 0 with v_count wrapping to 0. On that cycle active_scale updates and the offsets recompute; from the next cycle cfg_ready=1 again.
  - If the accept and the frame wrap occur in the same cycle, the value applies at the following frame wrap, not the current one.
- Mid-frame: active_scale, offsets and window geometry never change mid-frame.
- Reset asserted mid-frame: immediate return to the reset state, with any pending request dropped. After release, the counters restart from 0,0.

Test Plan:
- Reset release, default scale 6: x_off=16, y_off=168. The first in_window=1 occurs at h_count=256, v_count=196 (outputs one cycle later), with raster_x=0, raster_y=0. in_window is high for 768 pixels per line over 384 lines, and raster_x reaches 127 exactly on the last window pixel.
- Timing check over 2 frames: period 1040x748 clocks; one vs per frame at v=3, h=0; one hs per line at h=40, except on the vs cycle; 800x720 de cycles per frame.
- Write scale 5 mid-frame: cfg_ready drops the next cycle. The current frame completes at scale 6. The next frame has x_off=80, y_off=200, window 640x320. active_scale=5 from frame_start, and cfg_ready returns to 1.
- Second cfg_valid (scale 3) while a request is pending: not accepted (cfg_ready=0). The held request is accepted after apply and takes effect one frame later.
- cfg_scale=7, then cfg_scale=0: cfg_err pulses once each, active_scale stays unchanged, cfg_ready stays 1.
- reset_n pulsed low mid-window with scale 5 pending: outputs return to the reset values, and after release the first frame runs at scale 6 with no pending request.
